// File: rtl/num_entry_pkg.sv
// num_entry_pkg: shared constants and FSM state type for the number-entry block
//   BTN_*   : bit positions of the five buttons within btn
//   DEC_MAX : largest decimal digit, HEX_MAX : largest hex digit
//   NDIG    : number of editable digits
package num_entry_pkg;
   localparam int BTN_UP    = 0;
   localparam int BTN_DN    = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_CLR   = 4;
   localparam int NDIG      = 8;
   localparam logic [3:0] DEC_MAX = 4'd9;
   localparam logic [3:0] HEX_MAX = 4'd15;
   typedef enum logic {IDLE, CONV} state_t;
endpackage

// File: rtl/num_entry_debounce.sv
// debounce: 2-flop synchronizer followed by a stable-count level filter
//   clk, rst_n : clock and synchronous active-low reset
//   d          : raw asynchronous level
//   q          : debounced level, follows d after DB_N consecutive differing cycles
module debounce #(
   parameter int DB_N = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   localparam int CW = $clog2(DB_N + 1);
   logic s1, s2;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_n) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         cnt <= '0;
         q   <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         // any cycle where the synchronized level agrees with q restarts the count
         if (s2 == q) cnt <= '0;
         else if (cnt == CW'(DB_N - 1)) begin
            cnt <= '0;
            q   <= s2;
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/num_entry.sv
// num_entry: debounced button digit editor with sequential digits-to-binary converter
//   clk, rst_n : clock and synchronous active-low reset
//   mod        : raw base switch, 1 = hex, 0 = decimal
//   btn        : raw buttons [0] up [1] down [2] left [3] right [4] clear
//   digits     : packed nibbles, digit 7 leftmost
//   cursor     : index of the digit being edited
//   data       : binary value of digits in the current base
//   valid      : data matches digits
//   changed    : one-cycle pulse when data is reloaded
module num_entry
   import num_entry_pkg::*;
#(
   parameter int DB_N = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mod,
   input  logic [4:0]            btn,
   output logic [4*NDIG-1:0]     digits,
   output logic [2:0]            cursor,
   output logic [31:0]           data,
   output logic                  valid,
   output logic                  changed
);
   logic [4:0] lvl, lvl_d, ev;
   logic mode, mode_d, mode_chg;
   state_t state;
   logic [31:0] acc, acc_nx;
   logic [2:0] idx;
   logic [3:0] cur, dg, dmax;
   logic start;

   for (genvar i = 0; i < 5; i++) begin : g_btn
      debounce #(.DB_N(DB_N)) u_db (.clk(clk), .rst_n(rst_n), .d(btn[i]), .q(lvl[i]));
   end
   debounce #(.DB_N(DB_N)) u_mod (.clk(clk), .rst_n(rst_n), .d(mod), .q(mode));

   // press events and mode change are registered one cycle after the debounced level moves
   always_ff @(posedge clk)
      if (!rst_n) begin
         lvl_d    <= '0;
         ev       <= '0;
         mode_d   <= 1'b0;
         mode_chg <= 1'b0;
      end else begin
         lvl_d    <= lvl;
         ev       <= lvl & ~lvl_d;
         mode_d   <= mode;
         mode_chg <= mode ^ mode_d;
      end

   assign dmax   = mode ? HEX_MAX : DEC_MAX;
   assign cur    = digits[{cursor, 2'b00} +: 4];
   assign dg     = digits[{idx, 2'b00} +: 4];
   // decimal multiply by ten as shift-and-add
   assign acc_nx = mode ? {acc[27:0], dg} : (acc << 3) + (acc << 1) + {28'd0, dg};
   assign start  = mode_chg | ev[BTN_CLR] | ev[BTN_UP] | ev[BTN_DN];

   always_ff @(posedge clk)
      if (!rst_n) begin
         digits  <= '0;
         cursor  <= '0;
         data    <= '0;
         valid   <= 1'b1;
         changed <= 1'b0;
         state   <= IDLE;
         acc     <= '0;
         idx     <= '0;
      end else begin
         changed <= 1'b0;
         // the if-else chain drops lower-priority events arriving in the same cycle
         if (mode_chg) digits <= '0;
         else if (ev[BTN_CLR]) begin
            digits <= '0;
            cursor <= '0;
         end
         else if (ev[BTN_UP]) digits[{cursor, 2'b00} +: 4] <= (cur == dmax) ? 4'd0 : cur + 4'd1;
         else if (ev[BTN_DN]) digits[{cursor, 2'b00} +: 4] <= (cur == 4'd0) ? dmax : cur - 4'd1;
         else if (ev[BTN_LEFT]) cursor <= cursor + 3'd1;
         else if (ev[BTN_RIGHT]) cursor <= cursor - 3'd1;
         // a new digit edit always restarts conversion; data keeps its old value meanwhile
         if (start) begin
            state <= CONV;
            acc   <= '0;
            idx   <= 3'(NDIG - 1);
            valid <= 1'b0;
         end else if (state == CONV) begin
            acc <= acc_nx;
            idx <= idx - 3'd1;
            if (idx == 3'd0) begin
               data    <= acc_nx;
               valid   <= 1'b1;
               changed <= 1'b1;
               state   <= IDLE;
            end
         end
      end
endmodule
